engine_hour_meter: RTL and testbench

Upstream stage of the maintenance risk processor. It turns a time-base strobe and the engine-running status into a saturating 32-bit engine-hour count, and debounces eight raw fault inputs into sticky maintenance flags. Flags are cleared only through a four-phase request/acknowledge handshake. Both outputs are registered and drive the risk processor's `engine_hours` and `maintenance_flags` inputs directly.

---
 rtl/maint_pkg.sv | 20 ++
 rtl/fault_debouncer.sv | 50 +++++
 rtl/engine_hour_meter.sv | 102 ++++++++++
 tb/tb_engine_hour_meter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maint_pkg.sv
// Shared constants and types for the engine-hour / maintenance-flag front end.
package maint_pkg;

  localparam int FAULT_W = 8;

  localparam logic [FAULT_W-1:0] CRIT_MASK = 8'hF0;
  localparam logic [FAULT_W-1:0] ADV_MASK  = 8'h0F;
  localparam logic [31:0]        HOURS_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_ACK  = 1'b1
  } clr_state_t;

  // Saturating increment of the hour count.
  function automatic logic [31:0] hours_inc(input logic [31:0] hours);
    return (hours == HOURS_MAX) ? HOURS_MAX : hours + 32'd1;
  endfunction

endpackage

// File: rtl/fault_debouncer.sv
// One fault channel: counts consecutive tick samples with the fault high and
// sets a sticky flag once the count reaches DEBOUNCE_LEN.
module fault_debouncer #(
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic fault,
  input  logic clr,
  output logic flag
);

  localparam int CW = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN + 1) : 1;
  localparam logic [CW-1:0] LEN_C = CW'(DEBOUNCE_LEN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          flag_q;

  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != LEN_C) begin
      cnt_inc = cnt_q + CW'(1);
    end
  end

  // Clear beats a same-cycle set, so the whole count has to be re-earned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else if (tick) begin
      if (fault) begin
        cnt_q <= cnt_inc;
        if (cnt_inc == LEN_C) begin
          flag_q <= 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/engine_hour_meter.sv
// Engine-hour accumulator with load, eight debounced sticky fault flags and a
// four-phase request/acknowledge flag-clear handshake.
module engine_hour_meter
  import maint_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 3600,
  parameter int DEBOUNCE_LEN   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               engine_running,
  input  logic [FAULT_W-1:0] fault_in,
  input  logic               load_valid,
  input  logic [31:0]        load_hours,
  input  logic               clr_req,
  input  logic [FAULT_W-1:0] clr_mask,
  output logic               clr_ack,
  output logic [31:0]        engine_hours,
  output logic [FAULT_W-1:0] maintenance_flags,
  output clr_state_t         clr_state
);

  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_UNIT - 1);

  logic [PW-1:0]      presc_q;
  logic [31:0]        hours_q;
  clr_state_t         state_q;
  clr_state_t         state_next;
  logic [FAULT_W-1:0] clr_vec;
  logic               accrue;

  assign accrue = tick && engine_running;

  // Load wins over a same-cycle rollover; the pending increment is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      hours_q <= '0;
    end else if (load_valid) begin
      presc_q <= '0;
      hours_q <= load_hours;
    end else if (accrue) begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        hours_q <= hours_inc(hours_q);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  // Clear handshake (four-phase): clr_req is a level held by the requester.
  // An accepted request in CLR_IDLE clears the masked flags on that edge and
  // raises clr_ack; clr_ack stays high until clr_req is seen low, and the
  // requester may not raise clr_req again until clr_ack has dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    clr_vec    = '0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          clr_vec    = clr_mask;
          state_next = CLR_ACK;
        end
      end
      CLR_ACK: begin
        if (!clr_req) begin
          state_next = CLR_IDLE;
        end
      end
      default: state_next = CLR_IDLE;
    endcase
  end

  for (genvar i = 0; i < FAULT_W; i++) begin : g_deb
    fault_debouncer #(
      .DEBOUNCE_LEN(DEBOUNCE_LEN)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .fault(fault_in[i]),
      .clr  (clr_vec[i]),
      .flag (maintenance_flags[i])
    );
  end

  assign clr_ack      = (state_q == CLR_ACK);
  assign clr_state    = state_q;
  assign engine_hours = hours_q;

endmodule

// File: tb/tb_engine_hour_meter.sv
// Directed bench for engine_hour_meter with TICKS_PER_UNIT=4, DEBOUNCE_LEN=3.
module tb_engine_hour_meter;
  import maint_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        engine_running;
  logic [7:0]  fault_in;
  logic        load_valid;
  logic [31:0] load_hours;
  logic        clr_req;
  logic [7:0]  clr_mask;
  logic        clr_ack;
  logic [31:0] engine_hours;
  logic [7:0]  maintenance_flags;
  clr_state_t  clr_state;

  int total = 0;
  int bad   = 0;

  engine_hour_meter #(
    .TICKS_PER_UNIT(4),
    .DEBOUNCE_LEN  (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick             (tick),
    .engine_running   (engine_running),
    .fault_in         (fault_in),
    .load_valid       (load_valid),
    .load_hours       (load_hours),
    .clr_req          (clr_req),
    .clr_mask         (clr_mask),
    .clr_ack          (clr_ack),
    .engine_hours     (engine_hours),
    .maintenance_flags(maintenance_flags),
    .clr_state        (clr_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // drivers: inputs change 1 time unit after the rising edge, outputs are read there too
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step(1);
    end
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    total++;
    if (engine_hours !== 32'd0) begin
      bad++; $display("FAIL reset_hours: got %h want %h", engine_hours, 32'd0);
    end
    total++;
    if (maintenance_flags !== 8'h00) begin
      bad++; $display("FAIL reset_flags: got %h want %h", maintenance_flags, 8'h00);
    end
    total++;
    if (clr_ack !== 1'b0) begin
      bad++; $display("FAIL reset_ack: got %b want 0", clr_ack);
    end
    total++;
    if (clr_state !== CLR_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", clr_state, CLR_IDLE);
    end
  endtask

  task automatic test_accrual;
    engine_running = 1'b1;
    do_ticks(3);
    total++;
    if (engine_hours !== 32'd0) begin
      bad++; $display("FAIL accrue_3ticks: got %0d want 0", engine_hours);
    end
    do_ticks(1);
    total++;
    if (engine_hours !== 32'd1) begin
      bad++; $display("FAIL accrue_4ticks: got %0d want 1", engine_hours);
    end
    do_ticks(8);
    total++;
    if (engine_hours !== 32'd3) begin
      bad++; $display("FAIL accrue_12ticks: got %0d want 3", engine_hours);
    end
    engine_running = 1'b0;
    do_ticks(10);
    total++;
    if (engine_hours !== 32'd3) begin
      bad++; $display("FAIL accrue_stopped: got %0d want 3", engine_hours);
    end
  endtask

  task automatic test_saturation;
    load_valid = 1'b1;
    load_hours = 32'hFFFF_FFFE;
    step(1);
    load_valid = 1'b0;
    total++;
    if (engine_hours !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL load_value: got %h want %h", engine_hours, 32'hFFFF_FFFE);
    end
    engine_running = 1'b1;
    do_ticks(4);
    total++;
    if (engine_hours !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_reach: got %h want %h", engine_hours, 32'hFFFF_FFFF);
    end
    do_ticks(4);
    total++;
    if (engine_hours !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sat_hold: got %h want %h", engine_hours, 32'hFFFF_FFFF);
    end
    // load on the same cycle as a unit rollover
    load_valid = 1'b1;
    load_hours = 32'd0;
    step(1);
    load_valid = 1'b0;
    do_ticks(3);
    tick       = 1'b1;
    load_valid = 1'b1;
    load_hours = 32'd100;
    step(1);
    tick       = 1'b0;
    load_valid = 1'b0;
    total++;
    if (engine_hours !== 32'd100) begin
      bad++; $display("FAIL load_vs_roll: got %0d want 100", engine_hours);
    end
    do_ticks(3);
    total++;
    if (engine_hours !== 32'd100) begin
      bad++; $display("FAIL load_presc_zero: got %0d want 100", engine_hours);
    end
    do_ticks(1);
    total++;
    if (engine_hours !== 32'd101) begin
      bad++; $display("FAIL load_then_unit: got %0d want 101", engine_hours);
    end
    engine_running = 1'b0;
  endtask

  task automatic test_debounce;
    fault_in = 8'h20;
    do_ticks(2);
    fault_in = 8'h00;
    do_ticks(1);
    fault_in = 8'h20;
    do_ticks(2);
    total++;
    if (maintenance_flags !== 8'h00) begin
      bad++; $display("FAIL deb_early: got %h want %h", maintenance_flags, 8'h00);
    end
    do_ticks(1);
    total++;
    if (maintenance_flags !== 8'h20) begin
      bad++; $display("FAIL deb_set: got %h want %h", maintenance_flags, 8'h20);
    end
    fault_in = 8'h00;
    do_ticks(2);
    total++;
    if (maintenance_flags !== 8'h20) begin
      bad++; $display("FAIL deb_sticky: got %h want %h", maintenance_flags, 8'h20);
    end
  endtask

  task automatic test_clear;
    fault_in = 8'h01;
    do_ticks(3);
    fault_in = 8'h00;
    total++;
    if (maintenance_flags !== 8'h21) begin
      bad++; $display("FAIL clr_setup: got %h want %h", maintenance_flags, 8'h21);
    end
    clr_req  = 1'b1;
    clr_mask = 8'h01;
    step(1);
    clr_mask = 8'hFF;
    total++;
    if (maintenance_flags !== 8'h20) begin
      bad++; $display("FAIL clr_flags: got %h want %h", maintenance_flags, 8'h20);
    end
    total++;
    if (clr_ack !== 1'b1) begin
      bad++; $display("FAIL clr_ack_rise: got %b want 1", clr_ack);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      total++;
      if (clr_ack !== 1'b1 || maintenance_flags !== 8'h20) begin
        bad++;
        $display("FAIL clr_hold[%0d]: got ack=%b flags=%h want ack=1 flags=20", i, clr_ack, maintenance_flags);
      end
    end
    clr_req  = 1'b0;
    clr_mask = 8'h00;
    step(1);
    total++;
    if (clr_ack !== 1'b0) begin
      bad++; $display("FAIL clr_ack_fall: got %b want 0", clr_ack);
    end
    total++;
    if (clr_state !== CLR_IDLE) begin
      bad++; $display("FAIL clr_idle: got %0d want %0d", clr_state, CLR_IDLE);
    end
  endtask

  task automatic test_clear_on_set;
    fault_in = 8'h01;
    do_ticks(2);
    tick     = 1'b1;
    clr_req  = 1'b1;
    clr_mask = 8'h01;
    step(1);
    tick     = 1'b0;
    clr_req  = 1'b0;
    clr_mask = 8'h00;
    total++;
    if (maintenance_flags !== 8'h20) begin
      bad++; $display("FAIL cos_cleared: got %h want %h", maintenance_flags, 8'h20);
    end
    step(1);
    total++;
    if (clr_ack !== 1'b0) begin
      bad++; $display("FAIL cos_ack_fall: got %b want 0", clr_ack);
    end
    do_ticks(2);
    total++;
    if (maintenance_flags !== 8'h20) begin
      bad++; $display("FAIL cos_not_yet: got %h want %h", maintenance_flags, 8'h20);
    end
    do_ticks(1);
    total++;
    if (maintenance_flags !== 8'h21) begin
      bad++; $display("FAIL cos_reset: got %h want %h", maintenance_flags, 8'h21);
    end
    fault_in = 8'h00;
  endtask

  task automatic test_reset_mid;
    fault_in = 8'hFF;
    do_ticks(3);
    fault_in = 8'h00;
    clr_req  = 1'b1;
    clr_mask = 8'h00;
    step(1);
    total++;
    if (maintenance_flags !== 8'hFF || clr_ack !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup: got flags=%h ack=%b want flags=ff ack=1", maintenance_flags, clr_ack);
    end
    rst = 1'b1;
    step(1);
    total++;
    if (engine_hours !== 32'd0 || maintenance_flags !== 8'h00 || clr_ack !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got hours=%h flags=%h ack=%b want 0/00/0", engine_hours, maintenance_flags, clr_ack);
    end
    total++;
    if (clr_state !== CLR_IDLE) begin
      bad++; $display("FAIL rst_mid_state: got %0d want %0d", clr_state, CLR_IDLE);
    end
    rst     = 1'b0;
    clr_req = 1'b0;
    step(1);
  endtask

  initial begin
    rst            = 1'b1;
    tick           = 1'b0;
    engine_running = 1'b0;
    fault_in       = 8'h00;
    load_valid     = 1'b0;
    load_hours     = 32'd0;
    clr_req        = 1'b0;
    clr_mask       = 8'h00;
    test_reset();
    test_accrual();
    test_saturation();
    test_debounce();
    test_clear();
    test_clear_on_set();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
